// File: rtl/cordic_ln_pkg.sv
// Shared types and constants for the CORDIC natural-logarithm sequencer.
// Optional repeat iterations are enabled with CORDIC_REPEAT_ITER_EN.
package cordic_ln_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ITER = 3'd2,
    ST_OUT  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Hyperbolic CORDIC only converges if these indices run twice.
  localparam int REP0 = 4;
  localparam int REP1 = 13;
  localparam int REP2 = 40;

  localparam int DEF_ITER = 16;
  localparam int DEF_CW   = 6;

  function automatic logic is_rep_point(input logic [31:0] idx);
    return (idx == 32'(REP0)) || (idx == 32'(REP1)) || (idx == 32'(REP2));
  endfunction

endpackage

// File: rtl/cordic_ln_sequencer_if.sv
// Handshake and datapath-control bundle between the ln sequencer and its neighbours.
interface cordic_ln_sequencer_if #(
  parameter int CW = 6
);
  // start is taken only on an edge where ready=1; ack is taken only on an
  // edge where valid=1. Both are ignored at every other time, and all
  // outputs are registered, so neither input reaches an output combinationally.
  logic          start;
  logic          ack;
  logic          ready;
  logic          busy;
  logic          valid;
  logic          load_init;
  logic          load_iter;
  logic          load_out;
  logic [CW-1:0] shift;
  logic          rep;

  modport master (
    output start, ack,
    input  ready, busy, valid, load_init, load_iter, load_out, shift, rep
  );

  modport slave (
    input  start, ack,
    output ready, busy, valid, load_init, load_iter, load_out, shift, rep
  );

endinterface

// File: rtl/cordic_iter_counter.sv
// Shift-index counter with repeat tracking and last-iteration detection.
// Repeats of indices 4/13/40 are only generated when CORDIC_REPEAT_ITER_EN is defined.
module cordic_iter_counter
  import cordic_ln_pkg::*;
#(
  parameter int ITER = DEF_ITER,
  parameter int CW   = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init_i,
  input  logic          adv_i,
  output logic [CW-1:0] shift_o,
  output logic          rep_o,
  output logic          last_o
);

  logic [CW-1:0] idx_q, idx_d;
  logic          rep_q, rep_d;
  logic          at_rep_point;

`ifdef CORDIC_REPEAT_ITER_EN
  assign at_rep_point = is_rep_point(32'(idx_q));
`else
  assign at_rep_point = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      rep_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      rep_q <= rep_d;
    end
  end

  // Anything other than init/advance parks the index at 0 so shift reads 0 outside ITER.
  always_comb begin
    idx_d = '0;
    rep_d = 1'b0;
    if (init_i) begin
      idx_d = CW'(1);
    end else if (adv_i) begin
      if (at_rep_point && !rep_q) begin
        idx_d = idx_q;
        rep_d = 1'b1;
      end else begin
        idx_d = idx_q + CW'(1);
      end
    end
  end

  assign shift_o = idx_q;
  assign rep_o   = rep_q;
  assign last_o  = (idx_q == CW'(ITER)) && (!at_rep_point || rep_q);

endmodule

// File: rtl/cordic_ln_sequencer.sv
// Control FSM sequencing the CORDIC ln datapath: init load, iterations, result load.
// CORDIC_REPEAT_ITER_EN adds the repeated hyperbolic iterations (see cordic_iter_counter).
module cordic_ln_sequencer
  import cordic_ln_pkg::*;
#(
  parameter int ITER = DEF_ITER,
  parameter int CW   = DEF_CW
) (
  input  logic                    clk,
  input  logic                    rst,
  cordic_ln_sequencer_if.slave    seq_if,
  output state_t                  state_o
);

  state_t state_q, state_d;

  logic ready_q, busy_q, valid_q, load_init_q, load_iter_q, load_out_q;
  logic ready_d, busy_d, valid_d, load_init_d, load_iter_d, load_out_d;
  logic ctr_init, ctr_adv, ctr_last;

  cordic_iter_counter #(
    .ITER (ITER),
    .CW   (CW)
  ) u_iter_counter (
    .clk     (clk),
    .rst     (rst),
    .init_i  (ctr_init),
    .adv_i   (ctr_adv),
    .shift_o (seq_if.shift),
    .rep_o   (seq_if.rep),
    .last_o  (ctr_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      load_init_q <= 1'b0;
      load_iter_q <= 1'b0;
      load_out_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      load_init_q <= load_init_d;
      load_iter_q <= load_iter_d;
      load_out_q  <= load_out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (seq_if.start) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_ITER;
      ST_ITER: if (ctr_last) state_d = ST_OUT;
      ST_OUT:  state_d = ST_DONE;
      ST_DONE: if (seq_if.ack) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up with state_q.
  always_comb begin
    ready_d     = (state_d == ST_IDLE);
    busy_d      = (state_d == ST_LOAD) || (state_d == ST_ITER) || (state_d == ST_OUT);
    valid_d     = (state_d == ST_DONE);
    load_init_d = (state_d == ST_LOAD);
    load_iter_d = (state_d == ST_ITER);
    load_out_d  = (state_d == ST_OUT);
    ctr_init    = (state_q == ST_LOAD);
    ctr_adv     = (state_q == ST_ITER) && !ctr_last;
  end

  assign seq_if.ready     = ready_q;
  assign seq_if.busy      = busy_q;
  assign seq_if.valid     = valid_q;
  assign seq_if.load_init = load_init_q;
  assign seq_if.load_iter = load_iter_q;
  assign seq_if.load_out  = load_out_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_cordic_ln_sequencer.sv
// Self-checking bench for cordic_ln_sequencer: ITER=16 and ITER=1 instances,
// randomized start/ack noise, cycle-exact output checks against a sequence model.
module tb_cordic_ln_sequencer;
  import cordic_ln_pkg::*;

  localparam int CW = 6;
`ifdef CORDIC_REPEAT_ITER_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cordic_ln_sequencer_if #(.CW(CW)) if0 ();
  cordic_ln_sequencer_if #(.CW(CW)) if1 ();
  state_t st0, st1;

  cordic_ln_sequencer #(.ITER(16), .CW(CW)) dut0 (
    .clk     (clk),
    .rst     (rst),
    .seq_if  (if0.slave),
    .state_o (st0)
  );

  cordic_ln_sequencer #(.ITER(1), .CW(CW)) dut1 (
    .clk     (clk),
    .rst     (rst),
    .seq_if  (if1.slave),
    .state_o (st1)
  );

  logic start_v = 1'b0;
  logic ack_v   = 1'b0;
  int   sel     = 0;

  assign if0.start = start_v && (sel == 0);
  assign if0.ack   = ack_v   && (sel == 0);
  assign if1.start = start_v && (sel == 1);
  assign if1.ack   = ack_v   && (sel == 1);

  logic [12:0] obs0, obs1;
  assign obs0 = {if0.ready, if0.busy, if0.valid, if0.load_init, if0.load_iter,
                 if0.load_out, if0.rep, if0.shift};
  assign obs1 = {if1.ready, if1.busy, if1.valid, if1.load_init, if1.load_iter,
                 if1.load_out, if1.rep, if1.shift};

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: expected iteration sequence
  int exp_shift[$];
  bit exp_rep[$];

  task automatic build_seq(input int iter);
    exp_shift.delete();
    exp_rep.delete();
    for (int i = 1; i <= iter; i++) begin
      exp_shift.push_back(i);
      exp_rep.push_back(1'b0);
      if (REP_EN && (i == 4 || i == 13 || i == 40)) begin
        exp_shift.push_back(i);
        exp_rep.push_back(1'b1);
      end
    end
  endtask

  function automatic logic [12:0] mk(input bit r, input bit b, input bit v,
                                     input bit li, input bit lt, input bit lo,
                                     input bit rp, input int sh);
    return {r, b, v, li, lt, lo, rp, 6'(sh)};
  endfunction

  // scoreboard compare
  task automatic chk(input string tag, input logic [12:0] exp);
    logic [12:0] o;
    o = (sel == 1) ? obs1 : obs0;
    n_tests++;
    assert (o === exp) else begin
      n_fail++;
      $error("FAIL %s (dut%0d): observed %h expected %h", tag, sel, o, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: one full computation with random start/ack noise while not sampled
  task automatic run_txn(input int which, input int iter, input int hold,
                         input bit start_with_ack);
    sel = which;
    build_seq(iter);
    chk("idle", mk(1, 0, 0, 0, 0, 0, 0, 0));
    start_v = 1'b1;
    ack_v   = 1'($urandom_range(0, 1));
    step();
    chk("load", mk(0, 1, 0, 1, 0, 0, 0, 0));
    foreach (exp_shift[k]) begin
      start_v = 1'($urandom_range(0, 1));
      ack_v   = 1'($urandom_range(0, 1));
      step();
      chk("iter", mk(0, 1, 0, 0, 1, 0, exp_rep[k], exp_shift[k]));
    end
    start_v = 1'($urandom_range(0, 1));
    ack_v   = 1'($urandom_range(0, 1));
    step();
    chk("out", mk(0, 1, 0, 0, 0, 1, 0, 0));
    start_v = 1'($urandom_range(0, 1));
    ack_v   = 1'b0;
    step();
    chk("done", mk(0, 0, 1, 0, 0, 0, 0, 0));
    for (int h = 0; h < hold; h++) begin
      start_v = 1'($urandom_range(0, 1));
      step();
      chk("hold", mk(0, 0, 1, 0, 0, 0, 0, 0));
    end
    ack_v   = 1'b1;
    start_v = start_with_ack;
    step();
    ack_v   = 1'b0;
    start_v = 1'b0;
    chk("ack_idle", mk(1, 0, 0, 0, 0, 0, 0, 0));
    step();
    chk("no_restart", mk(1, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // reset in cycle 8 of ITER on the ITER=16 instance
  task automatic run_abort();
    sel = 0;
    build_seq(16);
    start_v = 1'b1;
    step();
    start_v = 1'b0;
    chk("abort_load", mk(0, 1, 0, 1, 0, 0, 0, 0));
    for (int k = 0; k < 8; k++) begin
      step();
      chk("abort_iter", mk(0, 1, 0, 0, 1, 0, exp_rep[k], exp_shift[k]));
    end
    rst = 1'b1;
    #1;
    chk("rst_async", mk(1, 0, 0, 0, 0, 0, 0, 0));
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < 25; c++) begin
      step();
      chk("post_rst", mk(1, 0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  initial begin
    #12;
    sel = 0;
    chk("reset0", mk(1, 0, 0, 0, 0, 0, 0, 0));
    sel = 1;
    chk("reset1", mk(1, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    step();
    run_txn(0, 16, 5, 1'b1);
    run_txn(0, 16, 0, 1'b0);
    run_txn(1, 1, 2, 1'b1);
    run_abort();
    for (int t = 0; t < 4; t++) begin
      run_txn(0, 16, $urandom_range(0, 5), 1'($urandom_range(0, 1)));
    end
    run_txn(1, 1, $urandom_range(0, 5), 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_ln_sequencer.md
# cordic_ln_sequencer

Control FSM for the CORDIC natural-logarithm datapath. It accepts a start request, then drives the load enables of the X/Y/Z and result registers plus the per-iteration shift index, so the hyperbolic CORDIC iterations run in the correct order. It holds the result-valid flag until the consumer acknowledges it. It sits between the system-level handshake and the load-enabled datapath registers.

## Interface
- ITER, 16, number of distinct hyperbolic iterations; shift index runs 1..ITER; legal range 1..63
- CW, 6, width of shift index and internal counters; must satisfy 2^CW > ITER
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request a new computation; sampled only while ready=1
- ack  in  1  consumer acknowledge; sampled only while valid=1
- ready  out  1  high in IDLE only
- busy  out  1  high in LOAD, ITER and OUT
- valid  out  1  high in DONE; result register holds ln output
- load_init  out  1  load X0/Y0/Z0 initial values (x=a+1, y=a-1, z=0)
- load_iter  out  1  load X/Y/Z with the next-iteration values
- load_out  out  1  load the result register from Z (2·z)
- shift  out  CW  current iteration index i, for the 2^-i shifts and the atanh LUT address
- rep  out  1  high when the current iteration is a repeated one

## Operation
- States: IDLE, LOAD, ITER, OUT, DONE (Moore outputs, all registered).
- IDLE: ready=1. start=1 → LOAD.
- LOAD: load_init=1 for one cycle → ITER, with shift=1.
- ITER: load_iter=1 every cycle. shift follows the iteration sequence. After the last sequence entry → OUT.
- OUT: load_out=1 for one cycle → DONE.
- DONE: valid=1, held until ack=1 → IDLE.
- Iteration sequence without repeats: 1, 2, …, ITER (N = ITER cycles).
- Only one load_* signal is high in any cycle. shift is 0 outside ITER.
- start is ignored outside IDLE. ack is ignored outside DONE.
- start=1 and ack=1 together in DONE: ack is honoured and start is dropped; the requester must reassert start in IDLE.
- Reset: state=IDLE, ready=1, busy=0, valid=0, all load_*=0, shift=0, rep=0.
- Reset mid-operation aborts immediately and asynchronously. No load_* pulse is issued after rst rises. Datapath contents are don't-care.

## Timing
- Edge 0 samples start. Cycle 1: LOAD. Cycles 2..N+1: ITER. Cycle N+2: OUT. Cycle N+3 onward: DONE.
- Start-to-valid latency: N+3 cycles.
- ack sampled at DONE edge → ready=1 in the next cycle. Minimum start-to-start spacing: N+4 cycles.
- shift and rep change on the same edge as the matching load_iter cycle. They are stable for the whole cycle.
- No combinational path from start/ack to any output.

## Configuration
- CORDIC_REPEAT_ITER_EN defined: iterations 4, 13 and 40 (those ≤ ITER) are executed twice, back-to-back. The second pass has rep=1. N = ITER + count of {4, 13, 40} ≤ ITER. Example: ITER=16 → N=18, sequence 1,2,3,4,4,5,…,13,13,14,15,16.
- CORDIC_REPEAT_ITER_EN undefined: no repeats, rep is tied to 0, and N = ITER.

## Structure
- Shared package cordic_ln_pkg holds:
  - the state enum (IDLE, LOAD, ITER, OUT, DONE)
  - the repeat-point constants REP0=4, REP1=13, REP2=40
  - the default ITER and CW values
- One sub-module, cordic_iter_counter, is natural. It provides:
  - the shift index, with clear and advance inputs
  - repeat detection (rep flag, second-pass tracking)
  - a last-iteration flag
- The FSM itself stays in cordic_ln_sequencer.

## Test plan
- Reset while idle, then a start pulse with ITER=16 and repeats off: load_init in cycle 1; load_iter in cycles 2–17 with shift 1..16; load_out in cycle 18; valid from cycle 19.
- Same run with CORDIC_REPEAT_ITER_EN defined: 18 load_iter cycles; shift shows 4,4 and 13,13 with rep=1 on the second of each pair; valid from cycle 21.
- Hold valid for 5 cycles with ack=0, then pulse ack: valid stays 1 throughout and drops after ack; ready=1 in the next cycle.
- Pulse start while busy, and pulse start and ack together in DONE: neither start is accepted; exactly one computation completes.
- Assert rst in cycle 8 of ITER: all outputs take their reset values immediately; with no further start, no load_* pulse occurs after rst falls.
- ITER=1 edge case: shift sequence is just 1; valid at cycle 4 (cycle 4 in both configurations, since no repeat point is ≤ 1).
